// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//   Turns one raw mechanical push-button into a clean debounced level plus
//   single-cycle press / release / auto-repeat event pulses, all aligned to
//   clk_in. Chain: 2-flop synchroniser -> counter-based debounce FSM ->
//   hold-to-repeat generator.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a press/release (>=2)
//   REPEAT_DELAY     HELD cycles before the first auto-repeat pulse     (>=1)
//   REPEAT_PERIOD    HELD cycles between subsequent repeat pulses       (>=1)
//
// Ports
//   clk_in             system clock, rising edge
//   resetn_in          asynchronous active-low reset
//   btn_in             raw asynchronous button, active-high
//   repeat_en_in       enables auto-repeat while held (synchronous)
//   level_out          debounced button level
//   press_pulse_out    one-cycle pulse on accepted press
//   release_pulse_out  one-cycle pulse on accepted release
//   repeat_pulse_out   one-cycle pulse per auto-repeat tick
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic clk_in,
    input  logic resetn_in,
    input  logic btn_in,
    input  logic repeat_en_in,
    output logic level_out,
    output logic press_pulse_out,
    output logic release_pulse_out,
    output logic repeat_pulse_out
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    // Guard the degenerate REPEAT_DELAY = REPEAT_PERIOD = 1 case, where
    // $clog2 would give a zero-width counter.
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // Two-stage synchroniser
    // -----------------------------------------------------------------------
    logic s1_q, s2_q;
    logic btn_sync;

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    assign btn_sync = s2_q;

    // -----------------------------------------------------------------------
    // Debounce FSM + repeat generator, all outputs registered
    // -----------------------------------------------------------------------
    state_e        state_q;
    logic [DW-1:0] dcnt_q;
    logic [RW-1:0] rcnt_q;
    logic          first_done_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          repeat_q;

    logic [DW-1:0] dcnt_inc;
    logic [RW-1:0] rcnt_inc;

    assign dcnt_inc = dcnt_q + 1'b1;
    assign rcnt_inc = rcnt_q + 1'b1;

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q      <= IDLE;
            dcnt_q       <= '0;
            rcnt_q       <= '0;
            first_done_q <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            repeat_q     <= 1'b0;
        end else begin
            // Pulses are single-cycle unless re-asserted below.
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (btn_sync) begin
                        state_q <= PRESS_CHK;
                        dcnt_q  <= '0;
                    end
                end

                PRESS_CHK: begin
                    if (!btn_sync) begin
                        // Bounce: drop back silently.
                        state_q <= IDLE;
                        dcnt_q  <= '0;
                    end else if (dcnt_q == DC_LAST) begin
                        state_q      <= HELD;
                        press_q      <= 1'b1;
                        level_q      <= 1'b1;
                        rcnt_q       <= '0;
                        first_done_q <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_inc;
                    end
                end

                HELD: begin
                    if (!btn_sync) begin
                        // rcnt is left untouched so a rejected glitch resumes
                        // the repeat cadence where it stopped.
                        state_q <= RELEASE_CHK;
                        dcnt_q  <= '0;
                    end else if (!repeat_en_in) begin
                        rcnt_q       <= '0;
                        first_done_q <= 1'b0;
                    end else if (!first_done_q && (rcnt_q == RD_LAST)) begin
                        repeat_q     <= 1'b1;
                        rcnt_q       <= '0;
                        first_done_q <= 1'b1;
                    end else if (first_done_q && (rcnt_q == RP_LAST)) begin
                        repeat_q <= 1'b1;
                        rcnt_q   <= '0;
                    end else begin
                        rcnt_q <= rcnt_inc;
                    end
                end

                RELEASE_CHK: begin
                    if (btn_sync) begin
                        state_q <= HELD;
                    end else if (dcnt_q == DC_LAST) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                        dcnt_q    <= '0;
                    end else begin
                        dcnt_q <= dcnt_inc;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    dcnt_q  <= '0;
                end
            endcase
        end
    end

    assign level_out         = level_q;
    assign press_pulse_out   = press_q;
    assign release_pulse_out = release_q;
    assign repeat_pulse_out  = repeat_q;

endmodule

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
//   Directed scenarios followed by randomised button activity, every cycle
//   compared against a reference model written in terms of run lengths of the
//   synchronised button and a count of enabled held ticks.
// ---------------------------------------------------------------------------
module tb_button_debounce;

    localparam int DC = 4;
    localparam int RD = 6;
    localparam int RP = 3;

    logic clk_in = 1'b0;
    logic resetn_in;
    logic btn_in;
    logic repeat_en_in;
    logic level_out, press_pulse_out, release_pulse_out, repeat_pulse_out;
    logic [3:0] obs;

    always #5 clk_in = ~clk_in;

    button_debounce #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk_in            (clk_in),
        .resetn_in         (resetn_in),
        .btn_in            (btn_in),
        .repeat_en_in      (repeat_en_in),
        .level_out         (level_out),
        .press_pulse_out   (press_pulse_out),
        .release_pulse_out (release_pulse_out),
        .repeat_pulse_out  (repeat_pulse_out)
    );

    // {level, press, release, repeat}
    assign obs = {level_out, press_pulse_out, release_pulse_out, repeat_pulse_out};

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic       m_h1, m_h2;   // btn sampled one / two edges ago
    logic       m_level;
    int         m_streak;     // edges the synced button has disagreed with level
    int         m_ticks;      // enabled held ticks since press / disable
    logic [3:0] m_exp;

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_h1 = 1'b0; m_h2 = 1'b0; m_level = 1'b0;
        m_streak = 0; m_ticks = 0; m_exp = 4'b0000;
    endtask

    task automatic model_step(input logic b, input logic en);
        logic sync, prs, rel, rep;
        sync = m_h2;
        m_h2 = m_h1;
        m_h1 = b;
        prs = 1'b0; rel = 1'b0; rep = 1'b0;
        if (!m_level) begin
            m_streak = sync ? m_streak + 1 : 0;
            // first high edge leaves IDLE, then DC more stable edges qualify
            if (m_streak == DC + 1) begin
                m_level = 1'b1; prs = 1'b1; m_streak = 0; m_ticks = 0;
            end
        end else if (!sync) begin
            m_streak++;
            if (m_streak == DC + 1) begin
                m_level = 1'b0; rel = 1'b1; m_streak = 0;
            end
        end else if (m_streak > 0) begin
            m_streak = 0;      // glitch rejected; this edge does not tick
        end else if (!en) begin
            m_ticks = 0;
        end else begin
            m_ticks++;
            if (m_ticks == RD || (m_ticks > RD && (m_ticks - RD) % RP == 0))
                rep = 1'b1;
        end
        m_exp = {m_level, prs, rel, rep};
    endtask

    // Called in the low clock phase; returns at the next falling edge.
    task automatic step(input logic b, input logic en);
        btn_in = b;
        repeat_en_in = en;
        @(posedge clk_in);
        model_step(b, en);
        #1;
        chk("cycle", {12'h0, obs}, {12'h0, m_exp});
        @(negedge clk_in);
    endtask

    // Reset pulse entirely between two rising edges.
    task automatic async_reset(input string tag);
        #2 resetn_in = 1'b0;
        model_reset();
        #1 chk(tag, {12'h0, obs}, 16'h0);
        #1 resetn_in = 1'b1;
    endtask

    initial begin
        logic [15:0] rv;
        logic [15:0] agg;
        logic        lvl_all;
        logic        cur_b, cur_en;
        int          run_left;

        resetn_in = 1'b0; btn_in = 1'b0; repeat_en_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        #1 chk("reset_state", {12'h0, obs}, 16'h0);
        resetn_in = 1'b1;
        @(negedge clk_in);

        // 1. Clean press, repeat disabled
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0);
            if (i == 6) chk("t1_before_e7", {12'h0, obs}, 16'h0000);
            if (i == 7) chk("t1_press_e7",  {12'h0, obs}, 16'h000C);
            if (i == 8) chk("t1_after_e7",  {12'h0, obs}, 16'h0008);
        end

        // Clean release, repeat disabled
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0);
            if (i == 6) chk("t5a_before", {12'h0, obs}, 16'h0008);
            if (i == 7) chk("t5a_release", {12'h0, obs}, 16'h0002);
            if (i == 8) chk("t5a_after", {12'h0, obs}, 16'h0000);
        end

        // 2. Press bounce
        agg = 16'h0;
        for (int i = 1; i <= 12; i++) begin
            step(i <= 2, 1'b0);
            agg = agg | {12'h0, obs};
        end
        chk("t2_bounce_quiet", agg, 16'h0);

        // 3. Auto-repeat; full 7-edge press latency shows FSM was back in IDLE
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b1);
            if (i == 7) chk("t3_press", {12'h0, obs}, 16'h000C);
        end
        rv = 16'h0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b1);
            rv[k] = obs[0];
        end
        chk("t3_repeat_P6_P9_P12", rv, 16'h1240);
        step(1'b1, 1'b0);
        rv = 16'h0;
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b1);
            rv[k] = obs[0];
        end
        chk("t3_reenable_Q6", rv, 16'h0040);

        // 4. Release glitch: two low samples, then held again
        rv = 16'h0; agg = 16'h0; lvl_all = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step(j > 2, 1'b1);
            rv[j] = obs[0];
            agg[0] = agg[0] | obs[1];
            lvl_all = lvl_all & obs[3];
        end
        chk("t4_no_release", agg, 16'h0);
        chk("t4_level_held", {15'h0, lvl_all}, 16'h1);
        chk("t4_cadence", rv, 16'h0904);

        // 5. Clean release with repeat enabled; repeats stop
        agg = 16'h0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1);
            if (i == 7) chk("t5_release", {12'h0, obs}, 16'h0002);
            if (i >= 3) agg[0] = agg[0] | obs[0];
        end
        chk("t5_repeat_stopped", agg, 16'h0);

        // 6. Async reset mid-PRESS_CHK (dcnt=2), button kept high
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1);
        async_reset("t6_reset_presschk");
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
            if (i == 6) chk("t6_before", {12'h0, obs}, 16'h0000);
            if (i == 7) chk("t6_press", {12'h0, obs}, 16'h000C);
        end
        // Reset while HELD: level must drop at once
        async_reset("t6_reset_held");

        // Randomised activity
        cur_b = btn_in; cur_en = 1'b1; run_left = 0;
        for (int n = 0; n < 1500; n++) begin
            if (run_left == 0) begin
                cur_b = ~cur_b;
                run_left = ($urandom_range(0, 2) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 4);
            end
            run_left--;
            if ($urandom_range(0, 15) == 0) cur_en = ~cur_en;
            step(cur_b, cur_en);
            if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
